// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter/sequencer for a 2^AW x DW single-port SRAM, zero-filled after reset.
// Optional write acknowledge responses: define SRAM_ARB_WRACK_EN.
module sram_port_arbiter #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [1:0]    req_we,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [DW-1:0] req_wdata0,
  input  logic [DW-1:0] req_wdata1,
  output logic [1:0]    rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          init_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam logic [AW-1:0] AddrMax = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic          iss_valid_q, iss_valid_d;
  logic          iss_port_q, iss_port_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    grant;
  logic          hs_port;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    iss_valid_d  = 1'b0;
    iss_port_d   = iss_port_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = rsp_rdata_q;
    grant        = 2'b00;
    hs_port      = 1'b0;

    // Response: sample the SRAM at the end of the issue cycle.
    if (iss_valid_q) begin
`ifdef SRAM_ARB_WRACK_EN
      rsp_valid_d[iss_port_q] = 1'b1;
      rsp_rdata_d             = mem_rdata;
`else
      if (!mem_we_q) begin
        rsp_valid_d[iss_port_q] = 1'b1;
        rsp_rdata_d             = mem_rdata;
      end
`endif
    end

    unique case (state_q)
      StInit: begin
        // Leave INIT only once the last word's write is on the SRAM pins.
        if (mem_we_q && mem_addr_q == AddrMax) begin
          state_d = StRun;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q;
          mem_wdata_d = '0;
          if (cnt_q != AddrMax) cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (req_valid == 2'b01)      grant = 2'b01;
        else if (req_valid == 2'b10) grant = 2'b10;
        else if (req_valid == 2'b11) grant = last_grant_q ? 2'b01 : 2'b10;

        if (grant != 2'b00) begin
          hs_port      = grant[1];
          iss_valid_d  = 1'b1;
          iss_port_d   = hs_port;
          last_grant_d = hs_port;
          mem_we_d     = req_we[hs_port];
          mem_addr_d   = hs_port ? req_addr1 : req_addr0;
          mem_wdata_d  = hs_port ? req_wdata1 : req_wdata0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StInit;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      iss_valid_q  <= 1'b0;
      iss_port_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      iss_valid_q  <= iss_valid_d;
      iss_port_q   <= iss_port_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = (state_q == StRun);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a behavioural 16x32 SRAM.
// Expectations for SRAM_ARB_WRACK_EN builds are selected by the same macro.
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [3:0]  req_addr0, req_addr1;
  logic [31:0] req_wdata0, req_wdata1;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        init_done;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int checks;
  int failures;

  sram_port_arbiter #(.AW(4), .DW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .init_done  (init_done),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  logic [31:0] sram [16];
  always @(posedge clk) if (mem_we) sram[mem_addr] <= mem_wdata;
  assign mem_rdata = sram[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reset released before the call: 16 zero-fill writes, then init_done.
  task automatic sweep();
    for (int k = 0; k < 16; k++) begin
      cyc();
      chk("init_we", {31'd0, mem_we}, 32'd1);
      chk("init_addr", {28'd0, mem_addr}, k);
      chk("init_wdata", mem_wdata, 32'd0);
      chk("init_done_low", {31'd0, init_done}, 32'd0);
      req_valid = (k < 15) ? 2'b11 : 2'b00;
      #1;
      chk("init_ready", {30'd0, req_ready}, 32'd0);
    end
    cyc();
    chk("init_done_high", {31'd0, init_done}, 32'd1);
    chk("run_idle_we", {31'd0, mem_we}, 32'd0);
  endtask

  task automatic wr(input logic port, input logic [3:0] addr, input logic [31:0] data);
    req_valid = port ? 2'b10 : 2'b01;
    req_we    = port ? 2'b10 : 2'b01;
    if (port) begin req_addr1 = addr; req_wdata1 = data; end
    else      begin req_addr0 = addr; req_wdata0 = data; end
    #1;
    chk("wr_ready", {30'd0, req_ready}, port ? 32'd2 : 32'd1);
    cyc();
    req_valid = 2'b00;
    req_we    = 2'b00;
    cyc();
    cyc();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_we = 2'b00;
    req_addr0 = '0;
    req_addr1 = '0;
    req_wdata0 = '0;
    req_wdata1 = '0;

    cyc(); cyc(); cyc();
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    rst_n = 1'b1;
    sweep();

    // First grant in the init_done cycle: read address 5.
    req_valid = 2'b01; req_we = 2'b00; req_addr0 = 4'd5;
    #1;
    chk("rd5_ready", {30'd0, req_ready}, 32'd1);
    cyc();
    req_valid = 2'b00;
    chk("rd5_mem_addr", {28'd0, mem_addr}, 32'd5);
    chk("rd5_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rd5_no_rsp_yet", {30'd0, rsp_valid}, 32'd0);
    cyc();
    chk("rd5_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("rd5_rsp_rdata", rsp_rdata, 32'd0);
    cyc();
    chk("rd5_rsp_pulse", {30'd0, rsp_valid}, 32'd0);

    // Port 0: write 3 then read 3 back-to-back.
    req_valid = 2'b01; req_we = 2'b01; req_addr0 = 4'd3; req_wdata0 = 32'hDEADBEEF;
    #1;
    chk("w3_ready", {30'd0, req_ready}, 32'd1);
    cyc();
    chk("w3_mem_we", {31'd0, mem_we}, 32'd1);
    chk("w3_mem_addr", {28'd0, mem_addr}, 32'd3);
    chk("w3_mem_wdata", mem_wdata, 32'hDEADBEEF);
    req_we = 2'b00;
    #1;
    chk("r3_ready", {30'd0, req_ready}, 32'd1);
    cyc();
    req_valid = 2'b00;
`ifdef SRAM_ARB_WRACK_EN
    chk("w3_ack_valid", {30'd0, rsp_valid}, 32'd1);
    chk("w3_ack_rdata", rsp_rdata, 32'd0);
`else
    chk("w3_no_rsp", {30'd0, rsp_valid}, 32'd0);
`endif
    cyc();
    chk("r3_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("r3_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    cyc();

    // Preload; last grant ends on port 1 so port 0 wins the first tie.
    wr(1'b0, 4'd1, 32'h11);
    wr(1'b1, 4'd2, 32'h22);

    req_valid = 2'b11; req_we = 2'b00; req_addr0 = 4'd1; req_addr1 = 4'd2;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin cyc(); #1; end
      chk("rr_ready", {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i >= 2) begin
        chk("rr_rsp_valid", {30'd0, rsp_valid}, (i % 2 == 0) ? 32'd1 : 32'd2);
        chk("rr_rsp_rdata", rsp_rdata, (i % 2 == 0) ? 32'h11 : 32'h22);
      end
    end

    // One-cycle reset in the middle of the stream.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("mid_rst_ready", {30'd0, req_ready}, 32'd0);
    chk("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    sweep();

    req_valid = 2'b10; req_we = 2'b00; req_addr1 = 4'd1;
    #1;
    chk("rd1_ready", {30'd0, req_ready}, 32'd2);
    cyc();
    req_valid = 2'b00;
    cyc();
    chk("rd1_rsp_valid", {30'd0, rsp_valid}, 32'd2);
    chk("rd1_rsp_rdata", rsp_rdata, 32'd0);
    cyc();

    // Port 1 writes 7 in T, port 0 reads 7 in T+1.
    req_valid = 2'b10; req_we = 2'b10; req_addr1 = 4'd7; req_wdata1 = 32'h12345678;
    #1;
    chk("w7_ready", {30'd0, req_ready}, 32'd2);
    cyc();
    req_valid = 2'b01; req_we = 2'b00; req_addr0 = 4'd7;
    #1;
    chk("r7_ready", {30'd0, req_ready}, 32'd1);
    chk("w7_mem_we", {31'd0, mem_we}, 32'd1);
    chk("w7_mem_addr", {28'd0, mem_addr}, 32'd7);
    cyc();
    req_valid = 2'b00;
`ifdef SRAM_ARB_WRACK_EN
    chk("w7_ack_valid", {30'd0, rsp_valid}, 32'd2);
    chk("w7_ack_rdata", rsp_rdata, 32'd0);
`else
    chk("w7_no_rsp", {30'd0, rsp_valid}, 32'd0);
`endif
    cyc();
    chk("r7_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("r7_rsp_rdata", rsp_rdata, 32'h12345678);
    cyc();

    // Two back-to-back writes of address 4.
    req_valid = 2'b01; req_we = 2'b01; req_addr0 = 4'd4; req_wdata0 = 32'hA5A5A5A5;
    #1;
    chk("w4a_ready", {30'd0, req_ready}, 32'd1);
    cyc();
    #1;
    chk("w4b_ready", {30'd0, req_ready}, 32'd1);
    cyc();
    req_valid = 2'b00; req_we = 2'b00;
`ifdef SRAM_ARB_WRACK_EN
    chk("w4a_ack_valid", {30'd0, rsp_valid}, 32'd1);
    chk("w4a_ack_rdata", rsp_rdata, 32'd0);
`else
    chk("w4a_no_rsp", {30'd0, rsp_valid}, 32'd0);
`endif
    cyc();
`ifdef SRAM_ARB_WRACK_EN
    chk("w4b_ack_valid", {30'd0, rsp_valid}, 32'd1);
    chk("w4b_ack_rdata", rsp_rdata, 32'hA5A5A5A5);
`else
    chk("w4b_no_rsp", {30'd0, rsp_valid}, 32'd0);
`endif
    cyc();

    req_valid = 2'b10; req_addr1 = 4'd4;
    #1;
    chk("r4_ready", {30'd0, req_ready}, 32'd2);
    cyc();
    req_valid = 2'b00;
    cyc();
    chk("r4_rsp_valid", {30'd0, rsp_valid}, 32'd2);
    chk("r4_rsp_rdata", rsp_rdata, 32'hA5A5A5A5);
    cyc();
    chk("idle_rsp_valid", {30'd0, rsp_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter and sequencer for one single-port, 16-word × 32-bit SRAM with a synchronous write and a combinational read. After reset it zero-fills the array, then grants each cycle to one of two requesters in round-robin order. It registers the winning command, drives the SRAM, and returns read data to the issuing port. It sits between the SRAM macro and the two masters that share it.

## Interface
- AW, 4, address width; the array holds 2^AW words.
- DW, 32, data width.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  2  per-port request valid.
- req_ready  out  2  per-port accept; one-hot or zero.
- req_we  in  2  per-port write (1) / read (0).
- req_addr0, req_addr1  in  AW  request address.
- req_wdata0, req_wdata1  in  DW  write data.
- rsp_valid  out  2  per-port response pulse, one cycle wide.
- rsp_rdata  out  DW  response data, shared by both ports.
- init_done  out  1  high once the zero-fill has completed.
- mem_addr  out  AW  SRAM address (registered).
- mem_wdata  out  DW  SRAM write data (registered).
- mem_we  out  1  SRAM write enable (registered).
- mem_rdata  in  DW  SRAM combinational read data for mem_addr.

## Operation
- FSM states: INIT and RUN. Reset enters INIT.
- INIT:
  - A counter walks 0 to 2^AW−1, one word per cycle, with mem_we=1 and mem_wdata=0.
  - req_ready is held at 0.
  - After the last word the FSM moves to RUN and init_done goes to 1.
- RUN, arbitration:
  - req_ready is combinational from req_valid and last_grant.
  - If exactly one port is valid, that port is granted.
  - If both are valid, the port ≠ last_grant is granted.
  - last_grant updates on every handshake and resets to 1, so port 0 wins the first tie.
- Handshake:
  - A handshake is req_valid[i] & req_ready[i].
  - The requester holds valid, we, addr and wdata stable until it is accepted.
  - Accepted fields are latched into the command register together with the port id.
- Issue:
  - On the cycle after acceptance, mem_addr, mem_wdata and mem_we drive the latched command.
  - With no accepted command, mem_we=0 and mem_addr/mem_wdata hold their values.
- Read response: mem_rdata is sampled at the end of the issue cycle into rsp_rdata, and rsp_valid[port] pulses for one cycle.
- Write response: none, unless the macro below is defined.
- Responses have no backpressure; the requester must accept them.
- Back-to-back grants are allowed every cycle, one access per cycle in total.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, mem_we=0, mem_addr=0, mem_wdata=0, FSM=INIT, counter=0, last_grant=1.
- Init sweep:
  - The first INIT write is in the first cycle after rst_n is sampled high.
  - init_done rises 2^AW cycles after reset release.
  - The first grant can occur in that same cycle.
- Latency:
  - Handshake in cycle T; SRAM access in T+1; rsp_valid and rsp_rdata valid in T+2.
  - A write commits at the end of T+1.
- Read-after-write:
  - A read accepted in T+1 after a write accepted in T returns the new data.
  - No forwarding is needed because the write commits before the read is issued.
- Reset mid-operation: in-flight commands are dropped, no response is produced, rsp_valid=0, and the sweep restarts from address 0.
- Address wrap: not applicable. Every address is in range; the INIT counter stops at 2^AW−1.

## Configuration
- SRAM_ARB_WRACK_EN
  - Defined: writes also produce a rsp_valid pulse at T+2. rsp_rdata carries the word's prior contents, i.e. mem_rdata sampled during the write cycle.
  - Undefined: writes produce no response, and rsp_valid only follows reads.

## Test plan
- Release reset → mem_we=1 for 16 cycles, addresses 0..15, data 0; init_done=1 at cycle 16; a read of address 5 returns 0x00000000.
- Port 0 writes address 3 = 0xDEADBEEF, then reads address 3 → rsp_valid[0] two cycles after the read handshake, with rsp_rdata=0xDEADBEEF; rsp_valid[1] stays 0.
- Both ports hold continuous reads of addresses 1 and 2, pre-loaded with 0x11 and 0x22 → grants go 0,1,0,1…; responses alternate rsp_valid[0]/0x11 and rsp_valid[1]/0x22, one per cycle.
- Port 1 writes address 7 = 0x12345678 in cycle T; port 0 reads address 7 in T+1 → port 0 receives 0x12345678 in T+3.
- Pull rst_n low for one cycle during the stream from the third scenario → the next cycle has rsp_valid=0 and req_ready=0, init_done=0 for 16 cycles, and a subsequent read of address 1 returns 0.
- With SRAM_ARB_WRACK_EN defined, write address 4 = 0xA5A5A5A5 twice → the first response carries 0x00000000 and the second carries 0xA5A5A5A5.
